// File: rtl/lsu_mem_if.sv
// Bundle of the core-side request/response and data-memory signals
// for the load/store unit.
interface lsu_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport slave (
        input  req_valid, mem_op, addr, wdata, rd_in,
        input  dmem_gnt, dmem_rvalid, dmem_rdata,
        output req_ready, resp_valid, resp_data, resp_rd, resp_err,
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
    );

    modport master (
        output req_valid, mem_op, addr, wdata, rd_in,
        output dmem_gnt, dmem_rvalid, dmem_rdata,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
    );
endinterface

// File: rtl/lsu_mem.sv
// Single-outstanding load/store unit: byte-lane steering, sign/zero
// extension, alignment checks and a request/response timeout.
module lsu_mem #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic       clk,
    input logic       rst,
    lsu_mem_if.slave  bus
);
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;

    logic          st_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [31:0]   addr_q, wdata_q, data_q;
    logic [3:0]    wstrb_q;
    logic [4:0]    rd_q;
    logic          err_q;

    logic          hs, st, ill, mis, bad;
    logic [2:0]    f3;
    logic [3:0]    strb;
    logic [31:0]   repl, lane, ext;

    assign st = bus.mem_op[3];
    assign f3 = bus.mem_op[2:0];
    assign hs = bus.req_valid & bus.req_ready;

    always_comb begin
        ill = 1'b0;
        if (st) ill = f3[2] | (f3[1:0] == 2'b11);
        else    ill = (f3 == 3'b011) | (f3[2:1] == 2'b11);
        mis = ((f3[1:0] == 2'b01) & bus.addr[0])
            | ((f3[1:0] == 2'b10) & (|bus.addr[1:0]));
        bad = ill | mis;
    end

    always_comb begin
        strb = 4'b1111;
        repl = bus.wdata;
        case (f3[1:0])
            2'b00: begin
                strb = 4'b0001 << bus.addr[1:0];
                repl = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                strb = 4'b0011 << {bus.addr[1], 1'b0};
                repl = {2{bus.wdata[15:0]}};
            end
            default: ;
        endcase
        if (!st) strb = 4'b0000;
    end

    // Shift the addressed lane down to bit 0, then extend per funct3.
    always_comb begin
        lane = bus.dmem_rdata >> {off_q, 3'b000};
        ext  = lane;
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'd0, lane[7:0]};
            3'b101:  ext = {16'd0, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = bad ? RESP : REQ;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (bus.dmem_gnt) begin
                    state_d = st_q ? RESP : WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == TLIM) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (bus.dmem_rvalid) begin
                    state_d = RESP;
                end else if (cnt_q == TLIM) begin
                    state_d = RESP;
                    tmo     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            if (hs) begin
                st_q    <= st;
                f3_q    <= f3;
                off_q   <= bus.addr[1:0];
                addr_q  <= {bus.addr[31:2], 2'b00};
                wdata_q <= repl;
                wstrb_q <= strb;
                rd_q    <= st ? 5'd0 : bus.rd_in;
                err_q   <= bad;
                data_q  <= 32'd0;
            end
            if (tmo) err_q <= 1'b1;
            if (state_q == WAIT && bus.dmem_rvalid) data_q <= ext;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) & ~rst;
    assign bus.resp_valid = (state_q == RESP) & ~rst;
    assign bus.resp_err   = bus.resp_valid & err_q;
    assign bus.resp_data  = bus.resp_valid ? data_q : 32'd0;
    assign bus.resp_rd    = bus.resp_valid ? rd_q : 5'd0;
    assign bus.dmem_req   = (state_q == REQ) & ~rst;
    assign bus.dmem_we    = bus.dmem_req & st_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wstrb = wstrb_q;
    assign bus.dmem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem built with TIMEOUT=4 so the abort
// paths are reachable in a handful of cycles.
module tb_lsu_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    lsu_mem_if bus();

    lsu_mem #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op when ready, then follow it to its response.
    // lat = cycle index (1 = first cycle after handshake) of resp_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          output int lat, output int reqn);
        int n;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        bus.mem_op    = op;
        bus.addr      = a;
        bus.wdata     = wd;
        bus.rd_in     = rd;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        lat  = -1;
        reqn = 0;
        for (int i = 1; i <= 20; i++) begin
            if (bus.dmem_req) reqn++;
            if (bus.resp_valid) begin
                lat = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.req_valid   = 1'b1;
        step();
        step();
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got=%b exp=0", bus.req_ready);
        end
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.dmem_req, bus.dmem_we} !== 4'b0) begin
            errors++;
            $display("FAIL rst_ctrl got=%b exp=0000",
                     {bus.resp_valid, bus.resp_err, bus.dmem_req, bus.dmem_we});
        end
        checks++;
        if ({bus.dmem_addr, bus.dmem_wstrb, bus.dmem_wdata, bus.resp_data, bus.resp_rd} !== '0) begin
            errors++;
            $display("FAIL rst_data addr=%h strb=%b wd=%h rdata=%h rd=%0d exp=0",
                     bus.dmem_addr, bus.dmem_wstrb, bus.dmem_wdata, bus.resp_data, bus.resp_rd);
        end
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got=%b exp=1", bus.req_ready);
        end
    endtask

    task automatic test_loads();
        int lat, reqn;
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h80AABBCC;
        run_op(4'b0000, 32'h1003, 32'h0, 5'd7, lat, reqn);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL lb_latency got=%0d exp=3", lat);
        end
        checks++;
        if (bus.resp_data !== 32'hFFFFFF80 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL lb_data got=%h err=%b exp=ffffff80 err=0",
                     bus.resp_data, bus.resp_err);
        end
        checks++;
        if (bus.resp_rd !== 5'd7) begin
            errors++;
            $display("FAIL lb_rd got=%0d exp=7", bus.resp_rd);
        end
        bus.dmem_rdata = 32'h9234ABCD;
        run_op(4'b0101, 32'h2002, 32'h0, 5'd3, lat, reqn);
        checks++;
        if (bus.resp_data !== 32'h00009234) begin
            errors++;
            $display("FAIL lhu_data got=%h exp=00009234", bus.resp_data);
        end
        run_op(4'b0001, 32'h2002, 32'h0, 5'd3, lat, reqn);
        checks++;
        if (bus.resp_data !== 32'hFFFF9234) begin
            errors++;
            $display("FAIL lh_data got=%h exp=ffff9234", bus.resp_data);
        end
        run_op(4'b0100, 32'h2001, 32'h0, 5'd4, lat, reqn);
        checks++;
        if (bus.resp_data !== 32'h000000AB) begin
            errors++;
            $display("FAIL lbu_data got=%h exp=000000ab", bus.resp_data);
        end
        run_op(4'b0010, 32'h2000, 32'h0, 5'd31, lat, reqn);
        checks++;
        if (bus.resp_data !== 32'h9234ABCD || bus.resp_rd !== 5'd31) begin
            errors++;
            $display("FAIL lw_data got=%h rd=%0d exp=9234abcd rd=31",
                     bus.resp_data, bus.resp_rd);
        end
    endtask

    task automatic test_stores();
        int n;
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b0;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        bus.mem_op    = 4'b1000;
        bus.addr      = 32'h3001;
        bus.wdata     = 32'h000000A5;
        bus.rd_in     = 5'd9;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 ||
            bus.dmem_addr !== 32'h3000 || bus.dmem_wstrb !== 4'b0010 ||
            bus.dmem_wdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL sb_bus req=%b we=%b addr=%h strb=%b wd=%h exp=1 1 3000 0010 a5a5a5a5",
                     bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_wstrb, bus.dmem_wdata);
        end
        step();
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rd !== 5'd0 ||
            bus.resp_err !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL sb_resp valid=%b rd=%0d err=%b req=%b exp=1 0 0 0",
                     bus.resp_valid, bus.resp_rd, bus.resp_err, bus.dmem_req);
        end
        step();
        bus.mem_op    = 4'b1001;
        bus.addr      = 32'h3002;
        bus.wdata     = 32'h1234BEEF;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.dmem_wstrb !== 4'b1100 || bus.dmem_wdata !== 32'hBEEFBEEF) begin
            errors++;
            $display("FAIL sh_bus strb=%b wd=%h exp=1100 beefbeef",
                     bus.dmem_wstrb, bus.dmem_wdata);
        end
        step();
        step();
        bus.mem_op    = 4'b1010;
        bus.addr      = 32'h3004;
        bus.wdata     = 32'hCAFEF00D;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.dmem_wstrb !== 4'b1111 || bus.dmem_wdata !== 32'hCAFEF00D ||
            bus.dmem_addr !== 32'h3004) begin
            errors++;
            $display("FAIL sw_bus strb=%b wd=%h addr=%h exp=1111 cafef00d 3004",
                     bus.dmem_wstrb, bus.dmem_wdata, bus.dmem_addr);
        end
        step();
    endtask

    task automatic test_errors();
        int lat, reqn;
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b1;
        run_op(4'b0010, 32'h4002, 32'h0, 5'd5, lat, reqn);
        checks++;
        if (lat !== 1 || reqn !== 0 || bus.resp_err !== 1'b1 || bus.resp_data !== 32'd0) begin
            errors++;
            $display("FAIL lw_misaligned lat=%0d reqs=%0d err=%b data=%h exp=1 0 1 0",
                     lat, reqn, bus.resp_err, bus.resp_data);
        end
        run_op(4'b1100, 32'h4000, 32'h0, 5'd5, lat, reqn);
        checks++;
        if (lat !== 1 || reqn !== 0 || bus.resp_err !== 1'b1) begin
            errors++;
            $display("FAIL store_illegal lat=%0d reqs=%0d err=%b exp=1 0 1",
                     lat, reqn, bus.resp_err);
        end
        run_op(4'b0011, 32'h4000, 32'h0, 5'd5, lat, reqn);
        checks++;
        if (lat !== 1 || reqn !== 0 || bus.resp_err !== 1'b1) begin
            errors++;
            $display("FAIL load_illegal lat=%0d reqs=%0d err=%b exp=1 0 1",
                     lat, reqn, bus.resp_err);
        end
        run_op(4'b0101, 32'h4001, 32'h0, 5'd5, lat, reqn);
        checks++;
        if (lat !== 1 || reqn !== 0 || bus.resp_err !== 1'b1) begin
            errors++;
            $display("FAIL lhu_misaligned lat=%0d reqs=%0d err=%b exp=1 0 1",
                     lat, reqn, bus.resp_err);
        end
    endtask

    task automatic test_timeout();
        int lat, reqn, n;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        run_op(4'b0010, 32'h5000, 32'h0, 5'd6, lat, reqn);
        checks++;
        if (lat !== 5 || reqn !== 4 || bus.dmem_req !== 1'b0 || bus.resp_err !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout lat=%0d reqs=%0d req=%b err=%b exp=5 4 0 1",
                     lat, reqn, bus.dmem_req, bus.resp_err);
        end
        step();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle ready=%b exp=1", bus.req_ready);
        end
        bus.dmem_gnt = 1'b1;
        run_op(4'b0010, 32'h5000, 32'h0, 5'd6, lat, reqn);
        checks++;
        if (lat !== 6 || reqn !== 1 || bus.resp_err !== 1'b1 || bus.resp_data !== 32'd0) begin
            errors++;
            $display("FAIL wait_timeout lat=%0d reqs=%0d err=%b data=%h exp=6 1 1 0",
                     lat, reqn, bus.resp_err, bus.resp_data);
        end
        // Grant lands in the last allowed cycle and must win.
        bus.dmem_gnt = 1'b0;
        step();
        bus.mem_op    = 4'b1010;
        bus.addr      = 32'h5008;
        bus.wdata     = 32'h1;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (n = 1; n < 4; n++) step();
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL gnt_wins valid=%b err=%b exp=1 0", bus.resp_valid, bus.resp_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h12345678;
        bus.mem_op      = 4'b0010;
        bus.addr        = 32'h6000;
        bus.rd_in       = 5'd8;
        bus.req_valid   = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_ready got=%b exp=1", bus.req_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            bus.dmem_rvalid = (i == 1);
            if (bus.resp_valid) seen++;
            step();
        end
        bus.dmem_rvalid = 1'b0;
        checks++;
        if (seen !== 0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_resp resp_cycles=%0d ready=%b exp=0 1",
                     seen, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int lat, reqn;
        bus.dmem_gnt    = 1'b1;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h7F00FF01;
        run_op(4'b0000, 32'h7002, 32'h0, 5'd1, lat, reqn);
        checks++;
        if (lat !== 3 || bus.resp_data !== 32'h00000000) begin
            errors++;
            $display("FAIL b2b_lb lat=%0d data=%h exp=3 00000000", lat, bus.resp_data);
        end
        run_op(4'b0000, 32'h7003, 32'h0, 5'd2, lat, reqn);
        checks++;
        if (lat !== 3 || bus.resp_data !== 32'h0000007F || bus.resp_rd !== 5'd2) begin
            errors++;
            $display("FAIL b2b_lb2 lat=%0d data=%h rd=%0d exp=3 0000007f 2",
                     lat, bus.resp_data, bus.resp_rd);
        end
        run_op(4'b0001, 32'h7000, 32'h0, 5'd2, lat, reqn);
        checks++;
        if (bus.resp_data !== 32'hFFFFFF01) begin
            errors++;
            $display("FAIL b2b_lh data=%h exp=ffffff01", bus.resp_data);
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.mem_op      = 4'd0;
        bus.addr        = 32'd0;
        bus.wdata       = 32'd0;
        bus.rd_in       = 5'd0;
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'd0;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter: TIMEOUT, default 255, max cycles spent in REQ or WAIT before the access aborts with an error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  a decoded memory operation is presented.
REQ-005 req_ready  output  1  block can accept an operation this cycle.
REQ-006 mem_op  input  4  {store, funct3}; bit3=1 store, bit3=0 load; funct3 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address (rs1 + imm, computed upstream).
REQ-008 wdata  input  32  store data (rs2 value).
REQ-009 rd_in  input  5  load destination register.
REQ-010 resp_valid  output  1  completion pulse.
REQ-011 resp_data  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_rd  output  5  rd_in of the completing operation; 0 for stores.
REQ-013 resp_err  output  1  misaligned, illegal mem_op or timeout.
REQ-014 dmem_req  output  1  memory request, held until granted.
REQ-015 dmem_we  output  1  1 = write.
REQ-016 dmem_addr  output  32  word address, {addr[31:2], 2'b00}.
REQ-017 dmem_wstrb  output  4  byte-lane write enables.
REQ-018 dmem_wdata  output  32  lane-replicated store data.
REQ-019 dmem_gnt  input  1  request accepted this cycle.
REQ-020 dmem_rvalid  input  1  read data valid; asserted no earlier than the cycle after dmem_gnt.
REQ-021 dmem_rdata  input  32  read data word.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, RESP. One operation in flight, no queuing.
REQ-023 req_ready = 1 only in IDLE with rst low; a handshake is req_valid & req_ready; mem_op, addr, wdata and rd_in are registered on the handshake.
REQ-024 Illegal: a load with funct3 of 011, 110 or 111; a store with funct3 other than 000, 001 or 010. Misaligned: H/HU with addr[0]=1; W with addr[1:0] != 0.
REQ-025 Illegal or misaligned: IDLE -> RESP directly, resp_err=1, dmem_req never asserted.
REQ-026 Otherwise IDLE -> REQ: dmem_req=1 with dmem_we, dmem_addr, dmem_wstrb and dmem_wdata stable until dmem_gnt.
REQ-027 Write strobes: B 0001<<addr[1:0]; H 0011<<{addr[1],0}; W 1111. Load strobes are 0000.
REQ-028 Write data: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-029 REQ with dmem_gnt: store -> RESP; load -> WAIT. dmem_req drops the cycle after grant.
REQ-030 WAIT with dmem_rvalid: capture, select lane by addr[1:0], extend, -> RESP. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
REQ-031 Timeout counter (8-bit minimum) clears on entry to REQ and on REQ->WAIT, increments each cycle in REQ/WAIT.
REQ-032 Counter reaching TIMEOUT without the awaited gnt/rvalid -> RESP with resp_err=1, dmem_req deasserted; a gnt/rvalid in that same cycle wins over timeout.
REQ-033 RESP: resp_valid=1 for exactly one cycle with resp_data, resp_rd and resp_err valid; then -> IDLE. No backpressure on the response.
REQ-034 Minimum latency from handshake to resp_valid: store 2 cycles, load 3 cycles, error 1 cycle.
REQ-035 dmem_gnt/dmem_rvalid in IDLE or RESP are ignored; no state change.

Reset
REQ-036 While rst is high: state IDLE, counter 0; req_ready, resp_valid, resp_err, dmem_req, dmem_we = 0; resp_data, resp_rd, dmem_addr, dmem_wstrb, dmem_wdata = 0.
REQ-037 rst mid-operation abandons the access; a late dmem_rvalid after reset is ignored; no resp_valid for the abandoned operation.

Verification
REQ-038 LB, addr 0x1003, rdata 0x80AABBCC, gnt and rvalid immediate -> resp_valid 3 cycles after handshake, resp_data 0xFFFFFF80, resp_err 0.
REQ-039 LHU, addr 0x2002, rdata 0x9234ABCD -> resp_data 0x00009234; LH with the same rdata -> 0xFFFF9234.
REQ-040 SB, addr 0x3001, wdata 0x000000A5 -> dmem_wstrb 0010, dmem_wdata 0xA5A5A5A5, dmem_addr 0x3000, dmem_we 1, resp_valid 2 cycles after handshake.
REQ-041 LW at addr 0x4002 and mem_op 4'b1100 -> resp_err 1 one cycle after handshake, dmem_req stays 0.
REQ-042 TIMEOUT=4, dmem_gnt held 0 -> dmem_req high for 4 cycles then low, resp_err 1, then IDLE with req_ready 1.
REQ-043 rst asserted in WAIT, rvalid pulsed 2 cycles later -> no resp_valid, req_ready 1 the cycle after rst falls.
